// File: rtl/prog_sequencer.sv
// Run controller: selects a benchmark program, loads its PC start address, enables the
// core until HALT or the cycle limit, then reports completion with a RUN-cycle count.
module prog_sequencer #(
  parameter logic [7:0]      START0     = 8'd0,
  parameter logic [7:0]      START1     = 8'd25,
  parameter logic [7:0]      START2     = 8'd44,
  parameter int unsigned     NPROG      = 3,
  parameter int unsigned     CYC_W      = 16,
  parameter logic [CYC_W-1:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sel_en,
  input  logic [1:0]       prog_sel,
  input  logic             halt,
  output logic             pc_load,
  output logic [7:0]       load_addr,
  output logic             run,
  output logic [1:0]       prog_id,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0]       LAST_ID  = 2'(NPROG - 1);
  localparam logic [CYC_W-1:0] LIMIT_M1 = MAX_CYCLES - 1'b1;

  state_t           state_q, state_d;
  logic [1:0]       next_id_q, next_id_d;
  logic [1:0]       prog_id_q, prog_id_d;
  logic [7:0]       addr_q, addr_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  function automatic logic [7:0] start_addr(input logic [1:0] id);
    case (id)
      2'd0:    start_addr = START0;
      2'd1:    start_addr = START1;
      default: start_addr = START2;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      next_id_q <= '0;
      prog_id_q <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      next_id_q <= next_id_d;
      prog_id_q <= prog_id_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    next_id_d = next_id_q;
    prog_id_d = prog_id_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    pc_load   = 1'b0;
    run       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // An explicit selection of a nonexistent program drops the start strobe.
        if (start && (!sel_en || (prog_sel <= LAST_ID))) begin
          prog_id_d = sel_en ? prog_sel : next_id_q;
          addr_d    = start_addr(prog_id_d);
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        pc_load = 1'b1;
        busy    = 1'b1;
        cnt_d   = '0;
        tmo_d   = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        run   = 1'b1;
        busy  = 1'b1;
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        // The limit compares the pre-increment count, so it fires on RUN cycle MAX_CYCLES.
        if (halt) begin
          state_d = S_DONE;
        end else if (cnt_q == LIMIT_M1) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        next_id_d = (prog_id_q == LAST_ID) ? '0 : prog_id_q + 2'd1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign load_addr   = addr_q;
  assign prog_id     = prog_id_q;
  assign timeout     = tmo_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a default-limit instance and an 8-cycle-limit instance share
// one directed stimulus and are both checked every cycle against a phase-level model.
module tb_prog_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       sel_en = 1'b0;
  logic [1:0] prog_sel = 2'd0;
  logic       halt = 1'b0;
  bit         go = 1'b0;

  int errors = 0;
  int checks = 0;

  logic        pc_load0, run0, busy0, done0, timeout0;
  logic [7:0]  load_addr0;
  logic [1:0]  prog_id0;
  logic [15:0] cc0;
  logic        pc_load1, run1, busy1, done1, timeout1;
  logic [7:0]  load_addr1;
  logic [1:0]  prog_id1;
  logic [15:0] cc1;

  prog_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .sel_en(sel_en), .prog_sel(prog_sel),
    .halt(halt), .pc_load(pc_load0), .load_addr(load_addr0), .run(run0),
    .prog_id(prog_id0), .busy(busy0), .done(done0), .timeout(timeout0), .cycle_count(cc0)
  );

  prog_sequencer #(.MAX_CYCLES(16'd8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .sel_en(sel_en), .prog_sel(prog_sel),
    .halt(halt), .pc_load(pc_load1), .load_addr(load_addr1), .run(run1),
    .prog_id(prog_id1), .busy(busy1), .done(done1), .timeout(timeout1), .cycle_count(cc1)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 loading, 2 running, 3 reporting done.
  int m_phase[2];
  int m_next[2];
  int m_pid[2];
  int m_cnt[2];
  bit m_tmo[2];
  int m_max[2] = '{65535, 8};
  int starts[3] = '{0, 25, 44};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_phase[k] <= 0;
        m_next[k]  <= 0;
        m_pid[k]   <= 0;
        m_cnt[k]   <= 0;
        m_tmo[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        case (m_phase[k])
          0: if (start && !(sel_en && prog_sel == 2'd3)) begin
               m_pid[k]   <= sel_en ? int'(prog_sel) : m_next[k];
               m_phase[k] <= 1;
             end
          1: begin
               m_cnt[k]   <= 0;
               m_tmo[k]   <= 1'b0;
               m_phase[k] <= 2;
             end
          2: begin
               if (m_cnt[k] < 65535) m_cnt[k] <= m_cnt[k] + 1;
               if (halt) m_phase[k] <= 3;
               else if (m_cnt[k] + 1 == m_max[k]) begin
                 m_phase[k] <= 3;
                 m_tmo[k]   <= 1'b1;
               end
             end
          default: begin
               m_next[k]  <= (m_pid[k] + 1) % 3;
               m_phase[k] <= 0;
             end
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_vec(input int k);
    logic [7:0]  a;
    logic [1:0]  id;
    logic [15:0] c;
    a  = 8'(starts[m_pid[k]]);
    id = 2'(m_pid[k]);
    c  = 16'(m_cnt[k]);
    exp_vec = {1'b0, m_phase[k] == 1, a, m_phase[k] == 2, id,
               (m_phase[k] == 1) || (m_phase[k] == 2), m_phase[k] == 3, m_tmo[k], c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (go) begin
      check("dut outputs vs model",
            {1'b0, pc_load0, load_addr0, run0, prog_id0, busy0, done0, timeout0, cc0}, exp_vec(0));
      check("dut8 outputs vs model",
            {1'b0, pc_load1, load_addr1, run1, prog_id1, busy1, done1, timeout1, cc1}, exp_vec(1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic se, input logic [1:0] ps, input logic [7:0] ea,
                        input logic [1:0] eid, input int unsigned n);
    start = 1'b1; sel_en = se; prog_sel = ps;
    tick();
    start = 1'b0; sel_en = 1'b0; prog_sel = 2'd0;
    check("load pc_load", pc_load0, 1);
    check("load addr", load_addr0, ea);
    check("load prog_id", prog_id0, eid);
    check("load run low", run0, 0);
    tick();
    check("run high", run0, 1);
    repeat (n - 1) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("done pulse", done0, 1);
    check("run low after halt", run0, 0);
    check("halt cycle_count", cc0, n);
    check("halt timeout", timeout0, 0);
    tick();
    check("done one cycle", done0, 0);
  endtask

  initial begin
    #1 reset = 1'b1;
    tick();
    tick();
    check("reset busy", busy0, 0);
    check("reset count", cc0, 0);
    reset = 1'b0;
    go = 1'b1;

    // Program 0 for 10 cycles; the 8-cycle instance times out first.
    launch(1'b0, 2'd0, 8'd0, 2'd0, 10);
    check("dut8 timeout set", timeout1, 1);
    check("dut8 timeout count", cc1, 8);
    check("count held in idle", cc0, 10);

    // Auto-advance and wrap.
    launch(1'b0, 2'd0, 8'd25, 2'd1, 3);
    launch(1'b0, 2'd0, 8'd44, 2'd2, 4);
    launch(1'b0, 2'd0, 8'd0, 2'd0, 2);

    // Halt coincides with the 8-cycle limit: halt wins.
    launch(1'b0, 2'd0, 8'd25, 2'd1, 8);
    check("dut8 collision timeout", timeout1, 0);
    check("dut8 collision count", cc1, 8);

    // Explicit selection, then an invalid selection.
    launch(1'b1, 2'd2, 8'd44, 2'd2, 3);
    start = 1'b1; sel_en = 1'b1; prog_sel = 2'd3;
    tick();
    start = 1'b0; sel_en = 1'b0; prog_sel = 2'd0;
    check("bad sel no pc_load", pc_load0, 0);
    check("bad sel not busy", busy0, 0);
    tick();

    // Start strobes during RUN and DONE are dropped.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("auto after sel addr", load_addr0, 0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start in run ignored", pc_load0, 0);
    check("still running", run0, 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    start = 1'b1;
    check("short run count", cc0, 2);
    tick();
    start = 1'b0;
    check("start in done ignored", busy0, 0);
    tick();
    check("start not queued", pc_load0, 0);

    // Reset mid-RUN.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("pre-reset addr", load_addr0, 25);
    tick();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("async run drop", run0, 0);
    check("async busy drop", busy0, 0);
    tick();
    tick();
    reset = 1'b0;
    check("reset clears addr", load_addr0, 0);
    launch(1'b0, 2'd0, 8'd0, 2'd0, 2);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
